meas_sched: RTL and testbench
=============================

# meas_sched

Measurement scheduler for the GPIO ring-oscillator stress test. It sequences one measurement cycle: clear both oscillator counters, open a fixed gate, latch both counters, and assemble the 11-byte UART frame with the latest BMP280 temperature. After a configurable number of samples it holds the oscillators in a halt window. It replaces the ad-hoc gate/latch/halt logic in the top level and sits between the `osc` instances, the `bmp280` sequencer and `uart_tx`.

## Interface
- `REF_CLK`, 10_000_000: gate length in `ref_clk` cycles (1 s at 10 MHz).
- `STP_SMPL`, 30: samples per run before a halt window; ≥1.
- `HALT_CYC`, 10_000_000: halt window length in cycles; ≥1.
- `LATCH_TMO`, 64: max cycles to wait for both latch acks; ≥2.
- `ref_clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `enable` in 1: run request.
- `osc_rst` out 1: one-cycle counter clear at gate start.
- `osc_halt` out 1: oscillators stopped.
- `latch_req` out 1: level request to both `osc` instances.
- `latch_ack` in 2: [0]=2v5, [1]=3v6.
- `cnt_2v5`, `cnt_3v6` in 32 each: latched counts.
- `temp_req` out 1: one-cycle BMP280 start.
- `temp_valid` in 1: one-cycle, new `temperature`.
- `temperature` in 20: raw BMP280 temperature.
- `tx_start` out 1: one-cycle frame start to `uart_tx`.
- `tx_busy` in 1: UART busy.
- `tx_data` out 88: frame, held stable from `tx_start` until the next frame.
- `sample_idx` out 8: samples in the current run (saturating).

## Operation
- States: IDLE, GATE, LATCH, FRAME, HALT.
- IDLE: `osc_halt`=1. When `enable`=1, go to GATE.
- GATE, entry cycle: `osc_rst`=1 and `temp_req`=1 for exactly one cycle. Stay in GATE for exactly `REF_CLK` cycles, then go to LATCH. `osc_halt`=0.
- LATCH: `latch_req`=1.
  - Ack sticky bits accumulate per channel.
  - When both are set, capture `cnt_3v6`/`cnt_2v5`, drop `latch_req`, go to FRAME.
  - After `LATCH_TMO` cycles without both acks: counts = 0, set `timeout`, go to FRAME.
- FRAME, one cycle:
  - Assemble `tx_data`: [87:56] `cnt_3v6`, [55:24] `cnt_2v5`, [23:4] `temp_reg`, [3:0] flags = {`overrun`, `timeout`, `stale`, `halt_next`}.
  - If `tx_busy`=0: pulse `tx_start`, clear `overrun`/`timeout`/`stale`.
  - If `tx_busy`=1: drop the frame, `tx_data` unchanged, set `overrun` (reported in the next sent frame).
  - Increment `sample_idx`.
  - Next state: IDLE if `enable`=0; else HALT if this was sample `STP_SMPL`; else GATE.
- HALT: `osc_halt`=1 for `HALT_CYC` cycles, `sample_idx`←0, then GATE, or IDLE if `enable`=0.
- `halt_next`=1 in the frame that precedes a HALT.
- `temp_reg` updates on `temp_valid`, and `stale` clears on the same cycle.
- `stale` is set on entering GATE and is cleared by `temp_valid` arriving before FRAME.
- `enable` is sampled only in IDLE, at FRAME exit and at HALT exit. Deasserting it mid-GATE/LATCH completes the sample.

## Timing
- Reset values: `osc_halt`=1, `osc_rst`=`latch_req`=`temp_req`=`tx_start`=0, `tx_data`=0, `sample_idx`=0, flags=0, `temp_reg`=0, state IDLE.
- `rst` mid-operation returns to IDLE on the next edge. No `tx_start` is issued in that cycle.
- First `osc_rst` is 1 cycle after `enable` is sampled high in IDLE.
- Period without timeout = 1 + `REF_CLK` + ack latency + 1. `latch_req` rises the cycle after the last GATE cycle.
- Acks arriving on different cycles are both honoured. An ack while not in LATCH is ignored.
- `temp_valid` and FRAME in the same cycle: the new value is used and `stale`=0.
- Ack on the timeout cycle: the ack wins and `timeout` stays clear.

## Structure
- `meas_sched_pkg`: state enum, flag bit indices, frame field offsets/widths (frame = 88 bits = 11 UART words).
- One sub-module `meas_timer`: loadable down-counter with a `zero` flag, reused for GATE, LATCH timeout and HALT. Width is `$clog2` of the maximum of the three parameters.

## Test plan
Bench parameters: `REF_CLK`=100, `STP_SMPL`=3, `HALT_CYC`=50, `LATCH_TMO`=8.
- Reset, `enable`=1, acks after 2 cycles, counts 0x1234/0xABCD, `temp_valid` with 0x5A5A5 mid-gate -> `osc_rst` one cycle after enable; `latch_req` 101 cycles later; `tx_data`=0xABCD_00001234_5A5A5_0; single `tx_start`.
- Three samples -> third frame flags=0x1; `osc_halt` high exactly 50 cycles; `sample_idx` back to 0; next `osc_rst` follows.
- Only `latch_ack[0]` asserted -> `latch_req` drops after 8 cycles; frame counts 0; flag `timeout` (0x4).
- `tx_busy`=1 during FRAME -> no `tx_start`, `tx_data` unchanged; next frame carries `overrun` (0x8).
- No `temp_valid` in a period -> `stale` (0x2) set, `temp_reg` holds the previous value.
- `rst` asserted mid-LATCH -> next cycle IDLE, all outputs at reset values, `osc_halt`=1.

Source files
------------

// File: rtl/meas_sched_pkg.sv
// Shared definitions for the measurement scheduler.
//   state_t  : scheduler FSM states
//   frame_t  : 88-bit UART frame (11 words): cnt_3v6 | cnt_2v5 | temperature | flags
//   FLAG_*   : bit positions inside the 4-bit flag field
//   max3     : helper used to size the shared timer
package meas_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GATE  = 3'd1,
        ST_LATCH = 3'd2,
        ST_FRAME = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam int unsigned FRAME_W = 88;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TEMP_W  = 20;
    localparam int unsigned FLAG_W  = 4;

    localparam int unsigned FLAG_HALT_NEXT = 0;
    localparam int unsigned FLAG_STALE     = 1;
    localparam int unsigned FLAG_TIMEOUT   = 2;
    localparam int unsigned FLAG_OVERRUN   = 3;

    // Field order fixes the bit offsets: [87:56] [55:24] [23:4] [3:0].
    typedef struct packed {
        logic [CNT_W-1:0]  cnt_3v6;
        logic [CNT_W-1:0]  cnt_2v5;
        logic [TEMP_W-1:0] temp;
        logic [FLAG_W-1:0] flags;
    } frame_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/meas_sched_timer.sv
// Loadable down-counter shared by the gate, latch-timeout and halt phases.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (takes priority over counting)
//   load_val  : value to load; the count then reaches zero load_val cycles later
//   zero      : count is zero (counter stops there)
module meas_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/meas_sched.sv
// Measurement scheduler: gate, latch and frame sequencing for the ring-oscillator
// stress test, with a periodic halt window.
//   ref_clk, rst          : clock, synchronous active-high reset
//   enable                : run request (sampled in IDLE, at FRAME exit, at HALT exit)
//   osc_rst, osc_halt     : oscillator counter clear pulse / oscillator stop
//   latch_req, latch_ack  : latch handshake with both osc instances ([0]=2v5, [1]=3v6)
//   cnt_2v5, cnt_3v6      : latched oscillator counts
//   temp_req, temp_valid,
//   temperature           : BMP280 start pulse / result strobe / raw value
//   tx_start, tx_busy,
//   tx_data               : UART frame handshake and frame contents
//   sample_idx            : samples taken in the current run (saturating)
module meas_sched
    import meas_sched_pkg::*;
#(
    parameter int unsigned REF_CLK   = 10_000_000,
    parameter int unsigned STP_SMPL  = 30,
    parameter int unsigned HALT_CYC  = 10_000_000,
    parameter int unsigned LATCH_TMO = 64
) (
    input  logic               ref_clk,
    input  logic               rst,
    input  logic               enable,
    output logic               osc_rst,
    output logic               osc_halt,
    output logic               latch_req,
    input  logic [1:0]         latch_ack,
    input  logic [CNT_W-1:0]   cnt_2v5,
    input  logic [CNT_W-1:0]   cnt_3v6,
    output logic               temp_req,
    input  logic               temp_valid,
    input  logic [TEMP_W-1:0]  temperature,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic [FRAME_W-1:0] tx_data,
    output logic [7:0]         sample_idx
);

    localparam int unsigned TMR_W = $clog2(max3(REF_CLK, HALT_CYC, LATCH_TMO));

    state_t             state, state_n;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_zero;

    logic [1:0]         ack_sticky;
    logic               both_now;
    logic               capture;
    logic               tmo_hit;
    logic               frame_sent;
    logic               frame_drop;
    logic               enter_gate;
    logic               last_smpl;

    logic [CNT_W-1:0]   cnt_2v5_r, cnt_3v6_r;
    logic [TEMP_W-1:0]  temp_reg;
    logic               stale, timeout, overrun;
    logic [FLAG_W-1:0]  flags;
    frame_t             frame;

    meas_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (ref_clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Acks seen this cycle count immediately, so an ack on the final
    // timeout cycle still completes the latch.
    assign both_now  = ((ack_sticky | latch_ack) == 2'b11);
    assign last_smpl = ((32'(sample_idx) + 32'd1) >= STP_SMPL);

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        capture    = 1'b0;
        tmo_hit    = 1'b0;
        frame_sent = 1'b0;
        frame_drop = 1'b0;
        osc_halt   = 1'b0;
        latch_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                osc_halt = 1'b1;
                if (enable) begin
                    state_n  = ST_GATE;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(REF_CLK - 1);
                end
            end
            ST_GATE: begin
                if (tmr_zero) begin
                    state_n  = ST_LATCH;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(LATCH_TMO - 1);
                end
            end
            ST_LATCH: begin
                latch_req = 1'b1;
                if (both_now) begin
                    capture = 1'b1;
                    state_n = ST_FRAME;
                end else if (tmr_zero) begin
                    tmo_hit = 1'b1;
                    state_n = ST_FRAME;
                end
            end
            ST_FRAME: begin
                frame_sent = !tx_busy;
                frame_drop = tx_busy;
                if (!enable) begin
                    state_n = ST_IDLE;
                end else if (last_smpl) begin
                    state_n  = ST_HALT;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HALT_CYC - 1);
                end else begin
                    state_n  = ST_GATE;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(REF_CLK - 1);
                end
            end
            ST_HALT: begin
                osc_halt = 1'b1;
                if (tmr_zero) begin
                    if (enable) begin
                        state_n  = ST_GATE;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(REF_CLK - 1);
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign enter_gate = (state_n == ST_GATE) && (state != ST_GATE);

    // A temperature strobe coinciding with FRAME is used directly.
    always_comb begin
        flags                 = '0;
        flags[FLAG_OVERRUN]   = overrun;
        flags[FLAG_TIMEOUT]   = timeout;
        flags[FLAG_STALE]     = stale && !temp_valid;
        flags[FLAG_HALT_NEXT] = enable && last_smpl;
        frame.cnt_3v6 = cnt_3v6_r;
        frame.cnt_2v5 = cnt_2v5_r;
        frame.temp    = temp_valid ? temperature : temp_reg;
        frame.flags   = flags;
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            osc_rst    <= 1'b0;
            temp_req   <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            sample_idx <= '0;
            ack_sticky <= '0;
            cnt_2v5_r  <= '0;
            cnt_3v6_r  <= '0;
            temp_reg   <= '0;
            stale      <= 1'b0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            osc_rst  <= enter_gate;
            temp_req <= enter_gate;
            // Registered so tx_data and tx_start change on the same edge.
            tx_start <= frame_sent;
            if (frame_sent) begin
                tx_data <= frame;
            end

            ack_sticky <= (state == ST_LATCH) ? (ack_sticky | latch_ack) : 2'b00;

            if (capture) begin
                cnt_2v5_r <= cnt_2v5;
                cnt_3v6_r <= cnt_3v6;
            end else if (tmo_hit) begin
                cnt_2v5_r <= '0;
                cnt_3v6_r <= '0;
            end

            if (temp_valid) begin
                temp_reg <= temperature;
            end

            // Entering GATE (possibly straight from a sent FRAME) must win.
            if (enter_gate) begin
                stale <= 1'b1;
            end else if (temp_valid || frame_sent) begin
                stale <= 1'b0;
            end

            if (tmo_hit) begin
                timeout <= 1'b1;
            end else if (frame_sent) begin
                timeout <= 1'b0;
            end

            if (frame_drop) begin
                overrun <= 1'b1;
            end else if (frame_sent) begin
                overrun <= 1'b0;
            end

            if (state == ST_HALT) begin
                sample_idx <= '0;
            end else if ((state == ST_FRAME) && (sample_idx != 8'hFF)) begin
                sample_idx <= sample_idx + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_meas_sched.sv
// Directed bench for meas_sched with short gate/halt/timeout settings.
module tb_meas_sched;

    logic        ref_clk;
    logic        rst;
    logic        enable;
    logic        osc_rst;
    logic        osc_halt;
    logic        latch_req;
    logic [1:0]  latch_ack;
    logic [31:0] cnt_2v5;
    logic [31:0] cnt_3v6;
    logic        temp_req;
    logic        temp_valid;
    logic [19:0] temperature;
    logic        tx_start;
    logic        tx_busy;
    logic [87:0] tx_data;
    logic [7:0]  sample_idx;

    int checks = 0;
    int errors = 0;

    meas_sched #(
        .REF_CLK   (100),
        .STP_SMPL  (3),
        .HALT_CYC  (50),
        .LATCH_TMO (8)
    ) dut (
        .ref_clk     (ref_clk),
        .rst         (rst),
        .enable      (enable),
        .osc_rst     (osc_rst),
        .osc_halt    (osc_halt),
        .latch_req   (latch_req),
        .latch_ack   (latch_ack),
        .cnt_2v5     (cnt_2v5),
        .cnt_3v6     (cnt_3v6),
        .temp_req    (temp_req),
        .temp_valid  (temp_valid),
        .temperature (temperature),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .sample_idx  (sample_idx)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // tv_mode: 0 = no temp_valid, 1 = mid-gate, 2 = in the FRAME cycle.
    // d0/d1: LATCH cycle index (0-based) of the ack pulse per channel, 99 = never.
    typedef struct {
        int          d0;
        int          d1;
        logic        busy;
        int          tv_mode;
        logic [19:0] temp;
        logic [31:0] c2;
        logic [31:0] c3;
        int          lat;
        logic        start;
        logic [87:0] data;
        logic [7:0]  idx;
        logic        halt;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(negedge ref_clk);
    endtask

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered on the negedge showing the first GATE cycle.
    task automatic run_period(input vec_t v, input int id);
        int n;
        int k;
        int h;
        int rst_cnt;
        int start_cnt;
        tx_busy     = v.busy;
        cnt_2v5     = v.c2;
        cnt_3v6     = v.c3;
        temperature = v.temp;
        check($sformatf("v%0d_osc_rst", id), 88'(osc_rst), 88'(1));
        check($sformatf("v%0d_temp_req", id), 88'(temp_req), 88'(1));
        check($sformatf("v%0d_osc_halt_gate", id), 88'(osc_halt), 88'(0));
        n = 0; rst_cnt = 0; start_cnt = 0;
        while (latch_req !== 1'b1 && n < 200) begin
            temp_valid = (v.tv_mode == 1 && n == 50);
            step();
            n++;
            if (osc_rst === 1'b1) rst_cnt++;
            if (tx_start === 1'b1) start_cnt++;
        end
        temp_valid = 1'b0;
        check($sformatf("v%0d_gate_len", id), 88'(n), 88'(100));
        check($sformatf("v%0d_osc_rst_single", id), 88'(rst_cnt), 88'(0));
        check($sformatf("v%0d_tx_start_single", id), 88'(start_cnt), 88'(0));
        k = 0;
        while (latch_req === 1'b1 && k < 20) begin
            latch_ack = {k == v.d1, k == v.d0};
            step();
            k++;
        end
        latch_ack = 2'b00;
        check($sformatf("v%0d_latch_len", id), 88'(k), 88'(v.lat));
        if (v.tv_mode == 2) temp_valid = 1'b1;
        step();
        temp_valid = 1'b0;
        check($sformatf("v%0d_tx_start", id), 88'(tx_start), 88'(v.start));
        check($sformatf("v%0d_tx_data", id), tx_data, v.data);
        check($sformatf("v%0d_sample_idx", id), 88'(sample_idx), 88'(v.idx));
        if (v.halt) begin
            check($sformatf("v%0d_halt_entry", id), 88'(osc_halt), 88'(1));
            h = 0;
            while (osc_halt === 1'b1 && h < 200) begin
                step();
                h++;
                if (h == 1) check($sformatf("v%0d_idx_cleared", id), 88'(sample_idx), 88'(0));
            end
            check($sformatf("v%0d_halt_len", id), 88'(h), 88'(50));
        end else begin
            check($sformatf("v%0d_no_halt", id), 88'(osc_halt), 88'(0));
        end
    endtask

    initial begin
        int n;

        //             d0  d1 busy tv temp       c2            c3            lat st data                                   idx halt
        vecs[0] = '{2,  2,  1'b0, 1, 20'h5A5A5, 32'h00001234, 32'h0000ABCD, 3, 1'b1, 88'h0000ABCD_00001234_5A5A5_0, 8'd1, 1'b0};
        vecs[1] = '{0,  99, 1'b0, 1, 20'h11111, 32'hDEADDEAD, 32'hBEEFBEEF, 8, 1'b1, 88'h00000000_00000000_11111_4, 8'd2, 1'b0};
        vecs[2] = '{1,  4,  1'b0, 1, 20'h22222, 32'h00000002, 32'h00000003, 5, 1'b1, 88'h00000003_00000002_22222_1, 8'd3, 1'b1};
        vecs[3] = '{2,  2,  1'b1, 1, 20'h33333, 32'h00000005, 32'h00000006, 3, 1'b0, 88'h00000003_00000002_22222_1, 8'd1, 1'b0};
        vecs[4] = '{7,  0,  1'b0, 2, 20'h44444, 32'h00000007, 32'h00000008, 8, 1'b1, 88'h00000008_00000007_44444_8, 8'd2, 1'b0};
        vecs[5] = '{0,  0,  1'b0, 0, 20'h55555, 32'h00000009, 32'h0000000A, 1, 1'b1, 88'h0000000A_00000009_44444_3, 8'd3, 1'b1};

        rst = 1'b1; enable = 1'b0; latch_ack = 2'b00; cnt_2v5 = '0; cnt_3v6 = '0;
        temp_valid = 1'b0; temperature = '0; tx_busy = 1'b0;
        repeat (3) step();
        check("rst_osc_halt", 88'(osc_halt), 88'(1));
        check("rst_osc_rst", 88'(osc_rst), 88'(0));
        check("rst_latch_req", 88'(latch_req), 88'(0));
        check("rst_temp_req", 88'(temp_req), 88'(0));
        check("rst_tx_start", 88'(tx_start), 88'(0));
        check("rst_tx_data", tx_data, 88'(0));
        check("rst_sample_idx", 88'(sample_idx), 88'(0));

        rst = 1'b0;
        step(); step();
        check("idle_osc_halt", 88'(osc_halt), 88'(1));
        check("idle_osc_rst", 88'(osc_rst), 88'(0));

        enable = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            run_period(vecs[i], i);
        end
        check("osc_rst_after_halt", 88'(osc_rst), 88'(1));

        // Reset in the middle of LATCH.
        n = 0;
        while (latch_req !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("rl_gate_len", 88'(n), 88'(100));
        step(); step();
        rst = 1'b1;
        step();
        check("rl_osc_halt", 88'(osc_halt), 88'(1));
        check("rl_latch_req", 88'(latch_req), 88'(0));
        check("rl_osc_rst", 88'(osc_rst), 88'(0));
        check("rl_temp_req", 88'(temp_req), 88'(0));
        check("rl_tx_start", 88'(tx_start), 88'(0));
        check("rl_tx_data", tx_data, 88'(0));
        check("rl_sample_idx", 88'(sample_idx), 88'(0));
        rst = 1'b0; enable = 1'b0;
        step(); step();
        check("rl_idle_osc_rst", 88'(osc_rst), 88'(0));
        check("rl_idle_osc_halt", 88'(osc_halt), 88'(1));

        // enable dropped mid-GATE: sample completes, then IDLE.
        cnt_2v5 = 32'h11; cnt_3v6 = 32'h22; tx_busy = 1'b0;
        enable = 1'b1;
        step();
        check("ed_osc_rst", 88'(osc_rst), 88'(1));
        enable = 1'b0;
        n = 0;
        while (latch_req !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("ed_gate_len", 88'(n), 88'(100));
        latch_ack = 2'b11;
        step();
        latch_ack = 2'b00;
        check("ed_latch_drop", 88'(latch_req), 88'(0));
        step();
        check("ed_tx_start", 88'(tx_start), 88'(1));
        check("ed_tx_data", tx_data, 88'h00000022_00000011_00000_2);
        check("ed_idle_halt", 88'(osc_halt), 88'(1));
        check("ed_sample_idx", 88'(sample_idx), 88'(1));
        step();
        check("ed_no_restart", 88'(osc_rst), 88'(0));
        check("ed_tx_start_single", 88'(tx_start), 88'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
